// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler
//   Round-robin arbiter sharing one resource among WIDTH requesters. A grant
//   is registered and held until the owner pulses its done bit, drops its
//   request, or has held the grant for MAX_HOLD cycles (MAX_HOLD=0: no limit).
//   After every release the priority pointer moves to the slot just past the
//   releasing owner, so a continuously requesting client is never starved.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   en         allows new grants to be issued; never cuts an active grant
//   requests   per-requester level request
//   done       per-requester release strobe; only the owner's bit is used
//   sel        registered one-hot grant, all-zero when idle
//   gnt_valid  registered, equals |sel
//   gnt_id     binary index of the owner, 0 when idle
//   timeout    one-cycle pulse on the first idle cycle after a forced release
module rr_grant_scheduler #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_HOLD = 8,
    localparam int unsigned IDW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] requests,
    input  logic [WIDTH-1:0] done,
    output logic [WIDTH-1:0] sel,
    output logic             gnt_valid,
    output logic [IDW-1:0]   gnt_id,
    output logic             timeout
);

    localparam int unsigned HCW = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   owner_q, owner_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic [WIDTH-1:0] sel_q, sel_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             timeout_q, timeout_d;

    logic [IDW-1:0]   winner;
    logic             found;
    int unsigned      idx;
    logic             grant_go;
    logic             hold_hit;
    logic             release_go;
    logic             timeout_go;

    // Winner search starting at ptr. The index is folded back below WIDTH
    // explicitly so non-power-of-two WIDTH wraps correctly.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= WIDTH) begin
                idx = idx - WIDTH;
            end
            if (!found && requests[IDW'(idx)]) begin
                found  = 1'b1;
                winner = IDW'(idx);
            end
        end
    end

    // Release causes, in priority order: done, request drop, hold limit.
    // timeout only fires when the hold limit is the sole reason.
    always_comb begin
        hold_hit   = (MAX_HOLD != 0) && (hold_q == HCW'(MAX_HOLD));
        grant_go   = (state_q == IDLE) && en && found;
        release_go = (state_q == BUSY) &&
                     (done[owner_q] || !requests[owner_q] || hold_hit);
        timeout_go = (state_q == BUSY) &&
                     !done[owner_q] && requests[owner_q] && hold_hit;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            hold_q      <= '0;
            sel_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            hold_q      <= hold_d;
            sel_q       <= sel_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            timeout_q   <= timeout_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                if (grant_go) begin
                    state_d = BUSY;
                    owner_d = winner;
                    hold_d  = HCW'(1);
                end
            end
            BUSY: begin
                if (release_go) begin
                    state_d = IDLE;
                    hold_d  = '0;
                    ptr_d   = (owner_q == IDW'(WIDTH - 1)) ? '0 : owner_q + IDW'(1);
                end else begin
                    hold_d  = hold_q + HCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic (values loaded into the output registers)
    always_comb begin
        sel_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
        timeout_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_go) begin
                    sel_d[winner] = 1'b1;
                    gnt_valid_d   = 1'b1;
                    gnt_id_d      = winner;
                end
            end
            BUSY: begin
                if (release_go) begin
                    timeout_d = timeout_go;
                end else begin
                    sel_d       = sel_q;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = owner_q;
                end
            end
            default: ;
        endcase
    end

    assign sel       = sel_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign timeout   = timeout_q;

endmodule
